fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Four-requester round-robin write arbiter feeding one shared single-clock FIFO.
// A grant lasts for one packet burst, capped at MAX_BURST words, and is followed by at least one idle cycle.
module fifo_wr_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [3:0]      last,
  input  logic [4*DW-1:0] din,
  output logic [3:0]      ack,
  output logic [3:0]      gnt,
  output logic            fifo_we,
  output logic [DW-1:0]   fifo_din,
  input  logic            fifo_full,
  output logic            busy
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  localparam logic [3:0] MAX_BEATS = 4'(MAX_BURST);

  state_t     state_q, state_d;
  logic [1:0] own_q, own_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] beat_q, beat_d;
  logic [3:0] gnt_q, gnt_d;
  logic [3:0] beat_inc;
  logic [1:0] rr_sel;
  logic [1:0] rr_idx;
  logic       rr_hit;
  logic       burst_end;

  // State register: reset returns to IDLE with requester 0 next in line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      own_q   <= 2'd0;
      ptr_q   <= 2'd3;
      beat_q  <= 4'd0;
      gnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      gnt_q   <= gnt_d;
    end
  end

  // Round-robin pick: first requester after the previous owner, wrapping.
  always_comb begin
    rr_sel = ptr_q;
    rr_idx = ptr_q;
    rr_hit = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      rr_idx = ptr_q + 2'(k);
      if (!rr_hit && req[rr_idx]) begin
        rr_sel = rr_idx;
        rr_hit = 1'b1;
      end
    end
  end

  assign beat_inc  = beat_q + 4'd1;
  assign burst_end = ~req[own_q] | (fifo_we & (last[own_q] | (beat_inc == MAX_BEATS)));

  // Next-state and grant bookkeeping.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = XFER;
          own_d   = rr_sel;
          gnt_d   = 4'b0001 << rr_sel;
          beat_d  = 4'd0;
        end
      end
      XFER: begin
        if (fifo_we) beat_d = beat_inc;
        if (burst_end) begin
          state_d = IDLE;
          ptr_d   = own_q;
          gnt_d   = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: the write path is combinational so a stall or reset blocks it in the same cycle.
  always_comb begin
    fifo_we  = (state_q == XFER) & req[own_q] & ~fifo_full & ~rst;
    ack      = fifo_we ? (4'b0001 << own_q) : 4'd0;
    fifo_din = (state_q == XFER) ? din[32'(own_q)*DW +: DW] : '0;
    gnt      = gnt_q;
    busy     = (state_q != IDLE);
  end

endmodule
